mini_alu_vga_core: RTL and testbench
====================================

Name: mini_alu_vga_core

Overview:
- Parametrised successor of the team's mini ALU CPU: a two-stage (fetch / execute) core with an internal resettable register file and an extended opcode set.
- Adds a pixel-write instruction that drives the VGA framebuffer write port through a valid/ready handshake.
- Branches flush the pipeline explicitly, and a HALT state is added.
- Sits between the instruction ROM and the framebuffer RAM wrapper, clocked by the 25 MHz pixel clock.

Parameters:
- DATA_WIDTH, 16, width of registers and ALU datapath
- REG_ADDR_WIDTH, 4, register file has 2**REG_ADDR_WIDTH entries; register fields use their low REG_ADDR_WIDTH bits
- IP_WIDTH, 16, instruction pointer width
- PIX_ADDR_WIDTH, 8, framebuffer row and column width
- RGB_WIDTH, 3, pixel colour width

Ports:
- Clock  in  1  core clock (25 MHz pixel clock)
- Reset  in  1  synchronous, active-high reset
- oInstrAddr  out  IP_WIDTH  ROM address (current IP)
- iInstruction  in  28  ROM data, combinational from oInstrAddr; fields: [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0
- oVgaWrValid  out  1  pixel write request
- iVgaWrReady  in  1  framebuffer accepts the write
- oVgaWrRow  out  PIX_ADDR_WIDTH  pixel row
- oVgaWrCol  out  PIX_ADDR_WIDTH  pixel column
- oVgaWrRGB  out  RGB_WIDTH  pixel colour
- oHalted  out  1  core halted

Behaviour:
Clocking and reset
- Single clock. Reset is synchronous and active-high.
- On any posedge with Reset=1: IP=0, IR=NOP, all registers=0, halted=0.
- Reset overrides stall, branch and halt.
- Outputs after reset: oInstrAddr=0, oVgaWrValid=0, oHalted=0. Row, column and RGB are don't-care while valid=0.

Pipeline
- Fetch: the instruction at IP is latched into IR at the posedge.
- Execute: operates on IR. Registers are read combinationally from IR.src1/IR.src0. The register write commits at the posedge.
- No forwarding is needed: a result written at edge N is visible to the instruction executing at edge N+1.
- Normal advance per posedge: IP<=IP+1 (wraps modulo 2**IP_WIDTH), IR<=iInstruction.

Opcodes (execute stage)
- 0 NOP: no effect.
- 1 ADD: R[dst]<=R[src1]+R[src0], modulo 2**DATA_WIDTH.
- 2 SUB: R[dst]<=R[src1]-R[src0], modulo 2**DATA_WIDTH.
- 3 STO: R[dst]<={src1,src0}, truncated or zero-extended to DATA_WIDTH.
- 4 BLE: if R[src1]<=R[src0] (unsigned), branch to dst.
- 5 JMP: unconditional branch to dst.
- 6 AND: R[dst]<=R[src1]&R[src0].
- 7 OR: R[dst]<=R[src1]|R[src0].
- 8 VGA_WR: row=R[src1][PIX_ADDR_WIDTH-1:0], col=R[src0][PIX_ADDR_WIDTH-1:0], RGB=dst[RGB_WIDTH-1:0].
- 15 HALT: stop the core.
- 9-14: treated as NOP.

Branch
- Taken branch: IP<=zero-extended dst, IR<=NOP.
- The already-fetched next instruction is discarded, giving exactly one bubble.
- Not-taken BLE advances normally.

VGA_WR handshake
- oVgaWrValid=1 combinationally whenever IR.op==VGA_WR and not halted.
- Valid never depends on iVgaWrReady.
- The transfer occurs at a posedge with valid & ready. At that edge the pipeline advances.
- While valid & !ready: IP and IR hold and row/col/RGB stay stable.
- Ready already high in the first cycle gives a 1-cycle write.
- Two back-to-back VGA_WR instructions with ready held high give two consecutive valid cycles.

Halt
- HALT in execute: at the posedge, halted<=1, IR<=NOP, IP holds.
- The core then stays idle with oHalted=1 until Reset.
- The instruction fetched behind HALT is discarded.

Reset during a stalled VGA_WR
- Valid drops in the cycle after the reset edge.
- No transfer is counted unless ready was high at that same edge.

Test Plan:
1. Reset held 2 cycles, then STO R1<=5, STO R2<=7, ADD R3<=R1+R2 -> R3=12 and oInstrAddr=0 on the first cycle after reset; SUB R4<=R1-R2 with DATA_WIDTH=16 -> R4=0xFFFE (wrap).
2. Loop: R1=0, R2=1, R3=3; ADD R1<=R1+R2; BLE R1<=R3 back to the ADD -> exactly 3 taken branches, one NOP bubble per branch (checked on the oInstrAddr trace), final R1=4.
3. VGA_WR with R1=10, R2=20, dst=3'b101 and iVgaWrReady low for 4 cycles -> valid high 5 cycles, row=10, col=20, RGB=5 stable throughout, oInstrAddr frozen, exactly one transfer when ready rises.
4. Two back-to-back VGA_WR with ready tied high -> two consecutive valid cycles with distinct coordinates, no stall.
5. HALT followed by STO R5<=9 -> oHalted=1 one cycle after HALT executes, R5 stays 0, oInstrAddr constant; Reset then clears oHalted and restarts at address 0.
6. Reset asserted while VGA_WR is stalled, ready low -> oVgaWrValid=0 the cycle after the reset edge, IP=0, all registers 0.

Source files
------------

// File: rtl/mini_alu_vga_core.sv
`default_nettype none
// ============================================================================
// Module   : mini_alu_vga_core
// Purpose  : Two-stage (fetch / execute) mini ALU core with a resettable
//            register file, branch flush, HALT state and a pixel-write
//            instruction driving a framebuffer write port (valid/ready).
// Ports    : Clock, Reset          - clock, synchronous active-high reset
//            oInstrAddr            - ROM address (current IP)
//            iInstruction          - ROM data {op,dst,src1,src0}
//            oVgaWrValid/iVgaWrReady - pixel write handshake
//            oVgaWrRow/Col/RGB     - pixel write payload
//            oHalted               - core halted
// Revision : 1.0 - initial release
// ============================================================================
module mini_alu_vga_core #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int IP_WIDTH       = 16,
  parameter int PIX_ADDR_WIDTH = 8,
  parameter int RGB_WIDTH      = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [IP_WIDTH-1:0]       oInstrAddr,
  input  logic [27:0]               iInstruction,
  output logic                      oVgaWrValid,
  input  logic                      iVgaWrReady,
  output logic [PIX_ADDR_WIDTH-1:0] oVgaWrRow,
  output logic [PIX_ADDR_WIDTH-1:0] oVgaWrCol,
  output logic [RGB_WIDTH-1:0]      oVgaWrRGB,
  output logic                      oHalted
);

  localparam int NREGS = 2 ** REG_ADDR_WIDTH;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_STO  = 4'd3;
  localparam logic [3:0] OP_BLE  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_VGA  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t                r_state;
  logic [IP_WIDTH-1:0]   r_ip;
  logic [27:0]           r_ir;
  logic [DATA_WIDTH-1:0] r_regs [NREGS];

  logic [3:0]            w_op;
  logic [7:0]            w_dst;
  logic [7:0]            w_src1;
  logic [7:0]            w_src0;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_we;
  logic                  w_taken;
  logic                  w_valid;
  logic                  w_stall;

  assign w_op   = r_ir[27:24];
  assign w_dst  = r_ir[23:16];
  assign w_src1 = r_ir[15:8];
  assign w_src0 = r_ir[7:0];

  // Register operands are read straight from IR; a write committed at the
  // previous edge is already visible here, so no forwarding is required.
  assign w_a = r_regs[w_src1[REG_ADDR_WIDTH-1:0]];
  assign w_b = r_regs[w_src0[REG_ADDR_WIDTH-1:0]];

  always_comb begin
    w_result = '0;
    w_we     = 1'b0;
    w_taken  = 1'b0;
    case (w_op)
      OP_ADD: begin w_result = w_a + w_b; w_we = 1'b1; end
      OP_SUB: begin w_result = w_a - w_b; w_we = 1'b1; end
      // Immediate {src1,src0} is resized (zero-extend or truncate) to the datapath.
      OP_STO: begin w_result = DATA_WIDTH'({w_src1, w_src0}); w_we = 1'b1; end
      OP_BLE: w_taken = (w_a <= w_b);
      OP_JMP: w_taken = 1'b1;
      OP_AND: begin w_result = w_a & w_b; w_we = 1'b1; end
      OP_OR:  begin w_result = w_a | w_b; w_we = 1'b1; end
      default: ;
    endcase
  end

  // Valid is a pure function of the executing instruction; ready only
  // decides whether the pipeline may move on.
  assign w_valid = (w_op == OP_VGA) && (r_state == S_RUN);
  assign w_stall = w_valid && !iVgaWrReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_RUN;
      r_ip    <= '0;
      r_ir    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_op == OP_HALT) begin
            // IP holds; the instruction fetched behind HALT is dropped.
            r_state <= S_HALT;
            r_ir    <= '0;
          end else if (w_stall) begin
            // Hold IP and IR so the pixel payload stays stable.
          end else if (w_taken) begin
            // Flush the already-fetched successor: one bubble.
            r_ip <= IP_WIDTH'(w_dst);
            r_ir <= '0;
          end else begin
            r_ip <= r_ip + IP_WIDTH'(1);
            r_ir <= iInstruction;
          end
          if (w_we) begin
            r_regs[w_dst[REG_ADDR_WIDTH-1:0]] <= w_result;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign oInstrAddr  = r_ip;
  assign oVgaWrValid = w_valid;
  assign oVgaWrRow   = w_a[PIX_ADDR_WIDTH-1:0];
  assign oVgaWrCol   = w_b[PIX_ADDR_WIDTH-1:0];
  assign oVgaWrRGB   = w_dst[RGB_WIDTH-1:0];
  assign oHalted     = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_vga_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_alu_vga_core
// Purpose  : Self-checking bench for mini_alu_vga_core. An instruction-level
//            model runs alongside the core; outputs and register contents are
//            compared every cycle, plus literal expectations per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_alu_vga_core;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oInstrAddr;
  logic [27:0] iInstruction;
  logic        oVgaWrValid;
  logic        iVgaWrReady = 1'b1;
  logic [7:0]  oVgaWrRow;
  logic [7:0]  oVgaWrCol;
  logic [2:0]  oVgaWrRGB;
  logic        oHalted;

  logic [27:0] rom [64];
  assign iInstruction = rom[oInstrAddr[5:0]];

  mini_alu_vga_core dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oInstrAddr   (oInstrAddr),
    .iInstruction (iInstruction),
    .oVgaWrValid  (oVgaWrValid),
    .iVgaWrReady  (iVgaWrReady),
    .oVgaWrRow    (oVgaWrRow),
    .oVgaWrCol    (oVgaWrCol),
    .oVgaWrRGB    (oVgaWrRGB),
    .oHalted      (oHalted)
  );

  always #20 Clock = ~Clock;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] ins(input int op, input int d, input int s1, input int s0);
    return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
  endfunction

  // ---------------- instruction-level reference model ----------------
  logic [15:0] m_ip;
  logic [27:0] m_ir;
  logic [15:0] m_regs [16];
  logic        m_halt;
  logic        m_known = 1'b0;

  always @(posedge Clock) begin
    int op;
    logic [15:0] a, b;
    logic [7:0]  d;
    logic        jump;
    if (Reset) begin
      m_ip = 0; m_ir = 0; m_halt = 0; m_known = 1'b1;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
    end else if (m_known && !m_halt) begin
      op   = int'(m_ir[27:24]);
      d    = m_ir[23:16];
      a    = m_regs[m_ir[11:8]];
      b    = m_regs[m_ir[3:0]];
      jump = 1'b0;
      if (op == 15) begin
        m_halt = 1'b1;
        m_ir   = 0;
      end else if (!(op == 8 && !iVgaWrReady)) begin
        case (op)
          1: m_regs[d[3:0]] = a + b;
          2: m_regs[d[3:0]] = a - b;
          3: m_regs[d[3:0]] = m_ir[15:0];
          4: jump = (a <= b);
          5: jump = 1'b1;
          6: m_regs[d[3:0]] = a & b;
          7: m_regs[d[3:0]] = a | b;
          default: ;
        endcase
        if (jump) begin
          m_ip = {8'h00, d};
          m_ir = 0;
        end else begin
          m_ir = rom[m_ip[5:0]];
          m_ip = m_ip + 16'd1;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge Clock) begin
    logic exp_valid;
    if (m_known) begin
      exp_valid = (m_ir[27:24] == 4'd8) && !m_halt;
      check("ip", oInstrAddr, m_ip);
      check("halted", oHalted, m_halt);
      check("valid", oVgaWrValid, exp_valid);
      if (exp_valid) begin
        check("row", oVgaWrRow, m_regs[m_ir[11:8]][7:0]);
        check("col", oVgaWrCol, m_regs[m_ir[3:0]][7:0]);
        check("rgb", oVgaWrRGB, m_ir[18:16]);
      end
      for (int i = 0; i < 16; i++) check("reg", dut.r_regs[i], m_regs[i]);
      if (oVgaWrValid && iVgaWrReady) n_xfer++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #3;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 28'd0;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 100 && !oVgaWrValid; k++) tick();
    check(name, oVgaWrValid, 1);
  endtask

  task automatic wait_halt(input string name);
    for (int k = 0; k < 100 && !oHalted; k++) tick();
    check(name, oHalted, 1);
  endtask

  initial begin
    logic [15:0] ip0, prev;
    int nbr, vcnt, x0;

    // 1: arithmetic, wrap, first address after reset
    clear_rom();
    rom[0] = ins(3, 1, 0, 5);
    rom[1] = ins(3, 2, 0, 7);
    rom[2] = ins(1, 3, 1, 2);
    rom[3] = ins(2, 4, 1, 2);
    rom[4] = ins(8, 0, 3, 4);
    rom[5] = ins(15, 0, 0, 0);
    iVgaWrReady = 1'b1;
    do_reset(2);
    check("t1_ip_after_reset", oInstrAddr, 0);
    check("t1_valid_after_reset", oVgaWrValid, 0);
    check("t1_halted_after_reset", oHalted, 0);
    wait_valid("t1_wait_valid");
    check("t1_row_r3", oVgaWrRow, 12);
    check("t1_col_r4", oVgaWrCol, 8'hFE);
    wait_halt("t1_wait_halt");
    check("t1_r3", dut.r_regs[3], 16'd12);
    check("t1_r4_wrap", dut.r_regs[4], 16'hFFFE);

    // 2: counted loop with BLE
    clear_rom();
    rom[0] = ins(3, 1, 0, 0);
    rom[1] = ins(3, 2, 0, 1);
    rom[2] = ins(3, 3, 0, 3);
    rom[3] = ins(1, 1, 1, 2);
    rom[4] = ins(4, 3, 1, 3);
    rom[5] = ins(8, 0, 1, 1);
    rom[6] = ins(15, 0, 0, 0);
    do_reset(1);
    nbr = 0;
    for (int k = 0; k < 100 && !oVgaWrValid; k++) begin
      prev = oInstrAddr;
      tick();
      if (oInstrAddr < prev) begin
        nbr++;
        check("t2_branch_target", oInstrAddr, 3);
        tick();
        check("t2_bubble_step", oInstrAddr, 4);
      end
    end
    check("t2_valid_seen", oVgaWrValid, 1);
    check("t2_taken_branches", nbr, 3);
    check("t2_final_r1", oVgaWrRow, 4);

    // 3: stalled pixel write
    clear_rom();
    rom[0] = ins(3, 1, 0, 10);
    rom[1] = ins(3, 2, 0, 20);
    rom[2] = ins(8, 5, 1, 2);
    rom[3] = ins(3, 5, 0, 1);
    rom[4] = ins(15, 0, 0, 0);
    iVgaWrReady = 1'b0;
    do_reset(1);
    wait_valid("t3_wait_valid");
    x0   = n_xfer;
    ip0  = oInstrAddr;
    check("t3_ip_at_stall", ip0, 3);
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (oVgaWrValid) vcnt++;
      check("t3_row", oVgaWrRow, 10);
      check("t3_col", oVgaWrCol, 20);
      check("t3_rgb", oVgaWrRGB, 5);
      check("t3_ip_frozen", oInstrAddr, ip0);
      if (k == 4) iVgaWrReady = 1'b1;
      tick();
    end
    check("t3_valid_cycles", vcnt, 5);
    check("t3_valid_dropped", oVgaWrValid, 0);
    check("t3_transfers", n_xfer - x0, 1);

    // 4: back-to-back pixel writes
    clear_rom();
    rom[0] = ins(3, 1, 0, 1);
    rom[1] = ins(3, 2, 0, 2);
    rom[2] = ins(8, 1, 1, 2);
    rom[3] = ins(8, 2, 2, 1);
    rom[4] = ins(15, 0, 0, 0);
    iVgaWrReady = 1'b1;
    do_reset(1);
    wait_valid("t4_wait_valid");
    x0 = n_xfer;
    check("t4_first", {oVgaWrRow, oVgaWrCol, 5'(oVgaWrRGB)}, {8'd1, 8'd2, 5'd1});
    tick();
    check("t4_second_valid", oVgaWrValid, 1);
    check("t4_second", {oVgaWrRow, oVgaWrCol, 5'(oVgaWrRGB)}, {8'd2, 8'd1, 5'd2});
    tick();
    check("t4_after", oVgaWrValid, 0);
    check("t4_transfers", n_xfer - x0, 2);

    // 5: HALT then reset
    clear_rom();
    rom[0] = ins(15, 0, 0, 0);
    rom[1] = ins(3, 5, 0, 9);
    do_reset(2);
    tick();
    check("t5_not_yet_halted", oHalted, 0);
    tick();
    check("t5_halted", oHalted, 1);
    check("t5_ip_hold", oInstrAddr, 1);
    repeat (3) tick();
    check("t5_still_halted", oHalted, 1);
    check("t5_ip_const", oInstrAddr, 1);
    check("t5_r5_zero", dut.r_regs[5], 0);
    do_reset(1);
    check("t5_unhalted", oHalted, 0);
    check("t5_restart_ip", oInstrAddr, 0);

    // 6: reset during stalled pixel write
    clear_rom();
    rom[0] = ins(3, 1, 0, 10);
    rom[1] = ins(3, 2, 0, 20);
    rom[2] = ins(8, 5, 1, 2);
    rom[3] = ins(15, 0, 0, 0);
    iVgaWrReady = 1'b0;
    do_reset(1);
    wait_valid("t6_wait_valid");
    repeat (2) tick();
    x0 = n_xfer;
    Reset = 1'b1;
    tick();
    check("t6_valid_after_reset", oVgaWrValid, 0);
    check("t6_ip_after_reset", oInstrAddr, 0);
    check("t6_r1_cleared", dut.r_regs[1], 0);
    check("t6_r2_cleared", dut.r_regs[2], 0);
    check("t6_no_transfer", n_xfer - x0, 0);
    Reset = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
